pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter LINE_W, 256, cache line / pmem data width in bits.
REQ-002 Parameter ADDR_W, 32, byte address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_read  input  1  instruction-cache line read request, held until i_resp.
REQ-006 i_address  input  ADDR_W  instruction-cache line address.
REQ-007 i_rdata  output  LINE_W  read line to instruction cache.
REQ-008 i_resp  output  1  one-cycle completion pulse to instruction cache.
REQ-009 d_read / d_write  input  1 each  data-cache read / writeback request, held until d_resp.
REQ-010 d_address  input  ADDR_W; d_wdata  input  LINE_W  data-cache address / writeback line.
REQ-011 d_rdata  output  LINE_W; d_resp  output  1  data-cache read line / completion pulse.
REQ-012 pmem_read, pmem_write  output  1; pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W  shared physical-memory request.
REQ-013 pmem_rdata  input  LINE_W; pmem_resp  input  1  physical-memory read data / completion pulse.

Function
REQ-014 FSM states IDLE, SERVE_I, SERVE_D; exactly one requester owns pmem at a time.
REQ-015 IDLE: all pmem_* request outputs 0; i_resp = d_resp = 0.
REQ-016 IDLE -> SERVE_D when (d_read|d_write) wins arbitration; IDLE -> SERVE_I when i_read wins; otherwise stay.
REQ-017 Fixed priority (macro absent): d-cache wins whenever both request in the same cycle.
REQ-018 SERVE_x: pmem_read/pmem_write/pmem_address/pmem_wdata driven combinationally from owner's inputs; non-owner inputs ignored.
REQ-019 SERVE_I: pmem_write = 0, pmem_wdata = 0.
REQ-020 pmem_resp routed combinationally to owner's resp only; non-owner resp held 0.
REQ-021 pmem_rdata broadcast to both i_rdata and d_rdata unconditionally.
REQ-022 SERVE_x -> IDLE on the cycle pmem_resp = 1; grant never changes mid-transaction.
REQ-023 Latency: request sampled in IDLE at edge k; pmem request asserted in cycle k+1; minimum one IDLE cycle between back-to-back grants.
REQ-024 Owner dropping its request before pmem_resp: arbiter holds grant and state until pmem_resp (protocol violation, flagged by assertion).
REQ-025 d_read and d_write both high: illegal; assertion fires, pmem_write takes precedence.

Reset
REQ-026 rst_n low: state = IDLE, all outputs 0, round-robin pointer = I, immediately and regardless of in-flight transaction.
REQ-027 In-flight pmem transaction is abandoned on reset; no resp forwarded.

Configuration
REQ-028 Macro PMEM_ARB_ROUND_ROBIN_EN defined: register last_grant updated on each grant; on simultaneous requests grant the requester not in last_grant; reset value I, so first contest goes to D.
REQ-029 Macro absent: no last_grant register; fixed d-cache priority per REQ-017.

Structure
REQ-030 Shared package rv_mem_pkg holds typedefs line_t (LINE_W), addr_t (ADDR_W), enum pmem_arb_state_t {IDLE, SERVE_I, SERVE_D}.
REQ-031 One sub-module pmem_arb_fsm: state register, arbitration, last_grant; top module holds only output muxing.

Verification
REQ-032 Single read: i_read=1, i_address=0x0000_0060, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1, pmem_address=0x60, i_resp pulse with i_rdata=0xA5..A5, d_resp=0.
REQ-033 Writeback: d_write=1, d_address=0x0000_1020, d_wdata=0x1234..  -> pmem_write=1 with same addr/data, d_resp on pmem_resp, i_resp=0.
REQ-034 Contention, fixed priority: i_read and d_read both at cycle 0 -> D served first, I granted after D's resp plus one IDLE cycle.
REQ-035 Contention, PMEM_ARB_ROUND_ROBIN_EN: four consecutive simultaneous request pairs -> grant order D, I, D, I.
REQ-036 Reset mid-transaction: rst_n low during SERVE_D before pmem_resp -> all outputs 0 same cycle, state IDLE, no d_resp after release.
REQ-037 Request switch during service: i_read rises while SERVE_D busy -> pmem_address unchanged until D's resp; I served next.

Source files
------------

// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_mem_pkg
//  Purpose  : Shared memory-side types for the cache / pmem arbiter slice:
//             line and address types, arbiter state and grant encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    localparam int PKG_LINE_W = 256;
    localparam int PKG_ADDR_W = 32;

    typedef logic [PKG_LINE_W-1:0] line_t;
    typedef logic [PKG_ADDR_W-1:0] addr_t;

    // Arbiter ownership state; IDLE must stay at zero so reset means "nobody owns pmem"
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } pmem_arb_state_t;

    // Identity of the most recent grant (round-robin build only)
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } pmem_grant_t;

endpackage
`default_nettype wire

// File: rtl/pmem_arb_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_arb_fsm
//  Purpose  : Ownership state machine for the shared pmem port. Decides which
//             cache owns pmem, holds the grant until pmem_resp, and (with
//             PMEM_ARB_ROUND_ROBIN_EN defined) alternates contested grants
//             using a last_grant register. Without the macro the data cache
//             always wins a contest.
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_arb_fsm
    import rv_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_read,
    input  logic            d_read,
    input  logic            d_write,
    input  logic            pmem_resp,
    output pmem_arb_state_t state
);

    pmem_arb_state_t state_next;
    logic            d_req;
    logic            d_wins_contest;

    assign d_req = d_read | d_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    pmem_grant_t last_grant;

    // A contest goes to whichever requester was not granted most recently
    assign d_wins_contest = (last_grant == GRANT_I);

    // Record the owner each time a grant is issued out of IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_I;
        end else if (state == IDLE && state_next == SERVE_D) begin
            last_grant <= GRANT_D;
        end else if (state == IDLE && state_next == SERVE_I) begin
            last_grant <= GRANT_I;
        end
    end
`else
    assign d_wins_contest = 1'b1;
`endif

    // Next-state: grant only from IDLE, release only on pmem_resp
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req && (d_wins_contest || !i_read)) begin
                    state_next = SERVE_D;
                end else if (i_read) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The owner must keep its request up until its completion pulse, and the
    // data cache must never ask for a read and a writeback at the same time.
    a_i_hold_req: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SERVE_I) |-> i_read);
    a_d_hold_req: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SERVE_D) |-> d_req);
    a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_read && d_write));

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_arbiter
//  Purpose  : Shares one physical-memory port between the instruction cache
//             and the data cache. Ownership comes from pmem_arb_fsm; this
//             level only steers request/response signals. Optional macro
//             PMEM_ARB_ROUND_ROBIN_EN selects alternating contest resolution
//             instead of fixed data-cache priority.
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction cache
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // data cache
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t state;

    pmem_arb_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .d_read    (d_read),
        .d_write   (d_write),
        .pmem_resp (pmem_resp),
        .state     (state)
    );

    // Steer the owner's request onto pmem and pmem_resp back to the owner only
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read    = i_read;
                pmem_address = i_address;
                i_resp       = pmem_resp;
            end
            SERVE_D: begin
                // a simultaneous read+write is illegal; the writeback wins
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    // Read data is shared by both caches; forced to zero while in reset
    assign i_rdata = rst_n ? pmem_rdata : '0;
    assign d_rdata = rst_n ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_arbiter
//  Purpose  : Self-checking bench for pmem_arbiter. A behavioural ownership
//             model predicts every output each cycle; directed scenarios add
//             hand-computed expectations (latency, data, grant order).
//             Honours PMEM_ARB_ROUND_ROBIN_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int NONE   = 0;
    localparam int OWN_I  = 1;
    localparam int OWN_D  = 2;

    typedef logic [LINE_W-1:0] vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mem_lat = 3;
    int mem_cnt = 0;
    int grant_log[$];
    int grant_cyc[$];

    pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- memory responder: pulse pmem_resp mem_lat cycles after request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_resp <= 1'b0;
            mem_cnt   <= 0;
        end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
            mem_cnt   <= 0;
        end else if (pmem_read || pmem_write) begin
            if (mem_cnt >= mem_lat - 1) pmem_resp <= 1'b1;
            else                        mem_cnt   <= mem_cnt + 1;
        end
    end

    // ---------------- behavioural model: who owns pmem
    int m_owner = NONE;
    int m_win;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    int m_last = OWN_I;
    function automatic int pick(input logic ir, input logic dr, input int last);
        if (ir && dr) return (last == OWN_D) ? OWN_I : OWN_D;
        if (dr) return OWN_D;
        if (ir) return OWN_I;
        return NONE;
    endfunction
`else
    function automatic int pick(input logic ir, input logic dr);
        if (dr) return OWN_D;
        if (ir) return OWN_I;
        return NONE;
    endfunction
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= NONE;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            m_last  <= OWN_I;
`endif
        end else if (m_owner == NONE) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            m_win = pick(i_read, d_read | d_write, m_last);
            if (m_win != NONE) m_last <= m_win;
`else
            m_win = pick(i_read, d_read | d_write);
`endif
            m_owner <= m_win;
        end else if (pmem_resp) begin
            m_owner <= NONE;
        end
    end

    // ---------------- per-cycle compare against the model
    logic              e_rd, e_wr, e_ir, e_dr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata, e_rdata;
    always @(negedge clk) begin
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_addr = '0; e_wdata = '0;
        e_rdata = rst_n ? pmem_rdata : '0;
        if (rst_n && m_owner == OWN_I) begin
            e_rd = i_read; e_addr = i_address; e_ir = pmem_resp;
        end else if (rst_n && m_owner == OWN_D) begin
            e_wr = d_write; e_rd = d_read & ~d_write;
            e_addr = d_address; e_wdata = d_wdata; e_dr = pmem_resp;
        end
        chk("pmem_read",    vec_t'(pmem_read),    vec_t'(e_rd));
        chk("pmem_write",   vec_t'(pmem_write),   vec_t'(e_wr));
        chk("pmem_address", vec_t'(pmem_address), vec_t'(e_addr));
        chk("pmem_wdata",   pmem_wdata,           e_wdata);
        chk("i_resp",       vec_t'(i_resp),       vec_t'(e_ir));
        chk("d_resp",       vec_t'(d_resp),       vec_t'(e_dr));
        chk("i_rdata",      i_rdata,              e_rdata);
        chk("d_rdata",      d_rdata,              e_rdata);
    end

    // ---------------- completion log (order and cycle of each resp pulse)
    always @(negedge clk) begin
        if (i_resp) begin grant_log.push_back(OWN_I); grant_cyc.push_back(cyc); end
        if (d_resp) begin grant_log.push_back(OWN_D); grant_cyc.push_back(cyc); end
    end

    // ---------------- requester drivers (back-to-back requests, held until resp)
    task automatic i_stream(input int n, input logic [ADDR_W-1:0] base);
        int waited;
        @(posedge clk); #1;
        i_read = 1'b1; i_address = base;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            @(negedge clk);
            while (!i_resp && waited < 200) begin waited++; @(negedge clk); end
            if (!i_resp) begin
                vectors++; miscompares++;
                $display("FAIL i_stream_timeout @%0t: got no i_resp required i_resp", $time);
            end
            @(posedge clk); #1;
            i_address = base + ADDR_W'(32'h40 * (k + 1));
        end
        i_read = 1'b0;
    endtask

    task automatic d_stream(input int n, input logic [ADDR_W-1:0] base, input logic wr,
                            input logic [LINE_W-1:0] wd);
        int waited;
        @(posedge clk); #1;
        d_read = ~wr; d_write = wr; d_address = base; d_wdata = wd;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            @(negedge clk);
            while (!d_resp && waited < 200) begin waited++; @(negedge clk); end
            if (!d_resp) begin
                vectors++; miscompares++;
                $display("FAIL d_stream_timeout @%0t: got no d_resp required d_resp", $time);
            end
            @(posedge clk); #1;
            d_address = base + ADDR_W'(32'h40 * (k + 1));
        end
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
    endtask

    task automatic clear_log();
        grant_log.delete();
        grant_cyc.delete();
    endtask

    // ---------------- directed scenarios
    initial begin
        int w;
        int seen;
        logic [LINE_W-1:0] wb;

        // reset state
        @(negedge clk);
        chk("rst_pmem_read",  vec_t'(pmem_read),  vec_t'(1'b0));
        chk("rst_pmem_write", vec_t'(pmem_write), vec_t'(1'b0));
        chk("rst_i_resp",     vec_t'(i_resp),     vec_t'(1'b0));
        chk("rst_d_resp",     vec_t'(d_resp),     vec_t'(1'b0));
        @(posedge clk); #2; rst_n = 1'b1;

        // single instruction read, latency 3
        mem_lat = 3; pmem_rdata = {32{8'hA5}};
        @(posedge clk); #1; i_read = 1'b1; i_address = 32'h0000_0060;
        @(negedge clk);
        chk("rd_idle_cycle", vec_t'(pmem_read), vec_t'(1'b0));
        @(negedge clk);
        chk("rd_pmem_read", vec_t'(pmem_read), vec_t'(1'b1));
        chk("rd_pmem_addr", vec_t'(pmem_address), vec_t'(32'h0000_0060));
        w = 0;
        do begin @(negedge clk); w++; end while (!i_resp && w < 50);
        chk("rd_resp_lat", vec_t'(w), vec_t'(3));
        chk("rd_i_resp", vec_t'(i_resp), vec_t'(1'b1));
        chk("rd_i_rdata", i_rdata, {32{8'hA5}});
        chk("rd_d_resp", vec_t'(d_resp), vec_t'(1'b0));
        @(posedge clk); #1; i_read = 1'b0;

        // data writeback, latency 2
        mem_lat = 2; wb = {8{32'h1234_5678}};
        @(posedge clk); #1; d_write = 1'b1; d_address = 32'h0000_1020; d_wdata = wb;
        @(negedge clk);
        @(negedge clk);
        chk("wb_pmem_write", vec_t'(pmem_write), vec_t'(1'b1));
        chk("wb_pmem_read", vec_t'(pmem_read), vec_t'(1'b0));
        chk("wb_pmem_addr", vec_t'(pmem_address), vec_t'(32'h0000_1020));
        chk("wb_pmem_wdata", pmem_wdata, wb);
        w = 0;
        do begin @(negedge clk); w++; end while (!d_resp && w < 50);
        chk("wb_d_resp", vec_t'(d_resp), vec_t'(1'b1));
        chk("wb_i_resp", vec_t'(i_resp), vec_t'(1'b0));
        @(posedge clk); #1; d_write = 1'b0;

        // simultaneous single requests: D first, I after one IDLE cycle
        do_reset();
        mem_lat = 2; pmem_rdata = {16{16'h5AC3}}; clear_log();
        fork
            i_stream(1, 32'h0000_0100);
            d_stream(1, 32'h0000_0200, 1'b0, '0);
        join
        chk("ct_count", vec_t'(grant_log.size()), vec_t'(2));
        if (grant_log.size() == 2) begin
            chk("ct_first", vec_t'(grant_log[0]), vec_t'(OWN_D));
            chk("ct_second", vec_t'(grant_log[1]), vec_t'(OWN_I));
            chk("ct_gap", vec_t'(grant_cyc[1] - grant_cyc[0]), vec_t'(4));
        end

        // four contested grants from two back-to-back streams
        do_reset();
        mem_lat = 1; clear_log();
        fork
            i_stream(2, 32'h0000_4000);
            d_stream(2, 32'h0000_8000, 1'b1, {4{64'hDEAD_BEEF_0BAD_F00D}});
        join
        chk("rr_count", vec_t'(grant_log.size()), vec_t'(4));
        if (grant_log.size() == 4) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            chk("rr_g0", vec_t'(grant_log[0]), vec_t'(OWN_D));
            chk("rr_g1", vec_t'(grant_log[1]), vec_t'(OWN_I));
            chk("rr_g2", vec_t'(grant_log[2]), vec_t'(OWN_D));
            chk("rr_g3", vec_t'(grant_log[3]), vec_t'(OWN_I));
`else
            chk("fp_g0", vec_t'(grant_log[0]), vec_t'(OWN_D));
            chk("fp_g1", vec_t'(grant_log[1]), vec_t'(OWN_D));
            chk("fp_g2", vec_t'(grant_log[2]), vec_t'(OWN_I));
            chk("fp_g3", vec_t'(grant_log[3]), vec_t'(OWN_I));
`endif
        end

        // instruction request arrives while the data cache is being served
        mem_lat = 4; clear_log();
        fork
            d_stream(1, 32'h0000_2000, 1'b0, '0);
            begin
                repeat (2) @(posedge clk);
                fork
                    i_stream(1, 32'h0000_3000);
                    begin
                        @(posedge clk); #1;
                        @(negedge clk);
                        chk("sw_addr_held", vec_t'(pmem_address), vec_t'(32'h0000_2000));
                        chk("sw_no_i_resp", vec_t'(i_resp), vec_t'(1'b0));
                    end
                join
            end
        join
        chk("sw_count", vec_t'(grant_log.size()), vec_t'(2));
        if (grant_log.size() == 2) begin
            chk("sw_first", vec_t'(grant_log[0]), vec_t'(OWN_D));
            chk("sw_second", vec_t'(grant_log[1]), vec_t'(OWN_I));
        end

        // reset in the middle of a data writeback
        mem_lat = 6; pmem_rdata = {32{8'h3C}};
        @(posedge clk); #1; d_write = 1'b1; d_address = 32'h0000_0A40; d_wdata = {64{4'h9}};
        repeat (2) @(posedge clk);
        #1;
        chk("mr_busy", vec_t'(pmem_write), vec_t'(1'b1));
        #1; rst_n = 1'b0;
        #1;
        chk("mr_pmem_write", vec_t'(pmem_write), vec_t'(1'b0));
        chk("mr_pmem_addr", vec_t'(pmem_address), vec_t'(32'h0));
        chk("mr_pmem_wdata", pmem_wdata, '0);
        chk("mr_d_rdata", d_rdata, '0);
        chk("mr_i_rdata", i_rdata, '0);
        d_write = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (d_resp || pmem_write || pmem_read) seen++;
        end
        chk("mr_quiet_after", vec_t'(seen), vec_t'(0));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
